muldiv_seq: RTL and testbench

Multi-cycle unsigned 16×16 multiply and 16/16 divide unit built around one shared 16-bit carry-lookahead adder. Shift-add multiply and restoring divide each run one adder operation per cycle for 16 cycles. The unit sits beside the single-cycle ALU: the decode stage starts it and stalls on `busy` until `done`.

---
 rtl/muldiv_seq_pkg.sv | 17 +
 rtl/muldiv_seq_cla_adder.sv | 81 ++++++++
 rtl/muldiv_seq.sv | 120 ++++++++++++
 tb/tb_muldiv_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// state encoding, operation codes and iteration count.
package muldiv_seq_pkg;

  localparam int MD_ITERS = 16;
  localparam logic [3:0] MD_LAST_CNT = 4'(MD_ITERS - 1);

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

endpackage

// File: rtl/muldiv_seq_cla_adder.sv
// Carry-lookahead adder/subtractor, 4-bit groups with a second lookahead
// level across groups. Subtraction inverts y and injects a carry-in of 1.
module muldiv_seq_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int GROUPS = WIDTH >> 2;

  logic [WIDTH-1:0]  y_eff;
  logic [WIDTH-1:0]  prop;
  logic [WIDTH-1:0]  gen;
  logic [WIDTH-1:0]  carry;
  logic [GROUPS-1:0] grp_gen;
  logic [GROUPS-1:0] grp_prop;
  logic [GROUPS:0]   grp_carry;

  always_comb begin
    y_eff = y ^ {WIDTH{sub}};
    prop  = x ^ y_eff;
    gen   = x & y_eff;
  end

  // Group generate/propagate, then carry into each group as a flat sum of products.
  always_comb begin
    logic acc;
    logic pr;
    grp_gen   = '0;
    grp_prop  = '0;
    grp_carry = '0;
    grp_carry[0] = sub;
    for (int k = 0; k < GROUPS; k++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int j = 3; j >= 0; j--) begin
        acc = acc | (pr & gen[(k << 2) + j]);
        pr  = pr & prop[(k << 2) + j];
      end
      grp_gen[k]  = acc;
      grp_prop[k] = pr;
    end
    for (int k = 0; k < GROUPS; k++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int j = GROUPS - 1; j >= 0; j--) begin
        if (j <= k) begin
          acc = acc | (pr & grp_gen[j]);
          pr  = pr & grp_prop[j];
        end
      end
      grp_carry[k+1] = acc | (pr & sub);
    end
  end

  // Bit carries inside a group look ahead from that group's carry-in.
  always_comb begin
    logic acc;
    logic pr;
    carry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int j = 2; j >= 0; j--) begin
        if (j < (i & 3)) begin
          acc = acc | (pr & gen[(i & ~3) + j]);
          pr  = pr & prop[(i & ~3) + j];
        end
      end
      carry[i] = acc | (pr & grp_carry[i >> 2]);
    end
  end

  assign sum  = prop ^ carry;
  assign cout = grp_carry[GROUPS];

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) and divide (restoring) sharing
// one carry-lookahead adder; one adder operation per cycle for 16 cycles.
module muldiv_seq #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] DBZ_QUOT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             dbz
);

  import muldiv_seq_pkg::*;

  md_state_t        state;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       cnt;
  logic             op_reg;
  logic             dbz_reg;

  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH-1:0] adder_x;
  logic [WIDTH-1:0] adder_sum;
  logic             adder_cout;
  logic             div_take;

  // Divide shifts the partial remainder left before subtracting; the bit
  // shifted out (HI msb) means the shifted remainder already exceeds B.
  assign rem_shift = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign adder_x   = (op_reg == MD_OP_DIV) ? rem_shift : hi;
  assign div_take  = hi[WIDTH-1] | adder_cout;

  muldiv_seq_cla_adder #(
    .WIDTH (WIDTH)
  ) cla_adder (
    .x    (adder_x),
    .y    (b_reg),
    .sub  (op_reg),
    .sum  (adder_sum),
    .cout (adder_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MD_IDLE;
      hi      <= '0;
      lo      <= '0;
      b_reg   <= '0;
      cnt     <= '0;
      op_reg  <= MD_OP_MUL;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            b_reg  <= b;
            cnt    <= '0;
            op_reg <= op;
            if ((op == MD_OP_DIV) && (b == '0)) begin
              hi      <= a;
              lo      <= DBZ_QUOT;
              dbz_reg <= 1'b1;
              state   <= MD_DONE;
            end else begin
              hi      <= '0;
              lo      <= a;
              dbz_reg <= 1'b0;
              state   <= MD_RUN;
            end
          end
        end
        MD_RUN: begin
          cnt <= cnt + 4'd1;
          if (op_reg == MD_OP_MUL) begin
            if (lo[0]) begin
              hi <= {adder_cout, adder_sum[WIDTH-1:1]};
              lo <= {adder_sum[0], lo[WIDTH-1:1]};
            end else begin
              hi <= {1'b0, hi[WIDTH-1:1]};
              lo <= {hi[0], lo[WIDTH-1:1]};
            end
          end else begin
            if (div_take) begin
              hi <= adder_sum;
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= rem_shift;
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end
          if (cnt == MD_LAST_CNT) begin
            state <= MD_DONE;
          end
        end
        MD_DONE: begin
          state <= MD_IDLE;
        end
        default: begin
          state <= MD_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != MD_IDLE);
  assign done      = (state == MD_DONE);
  assign result_hi = hi;
  assign result_lo = lo;
  assign dbz       = dbz_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, random ops against
// an arithmetic reference model, held-start throughput and mid-run reset.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result_hi;
  logic [15:0] result_lo;
  logic        dbz;

  int tests_run;
  int tests_failed;

  typedef struct {
    string       name;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  logic        held_op[54];
  logic [15:0] held_a[54];
  logic [15:0] held_b[54];

  muldiv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {dbz, hi, lo} straight from the arithmetic definition.
  function automatic logic [32:0] refModel(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i);
    logic [31:0] prod;
    if (op_i && (b_i == 16'd0)) begin
      return {1'b1, a_i, 16'hFFFF};
    end else if (op_i) begin
      return {1'b0, a_i % b_i, a_i / b_i};
    end else begin
      prod = 32'(a_i) * 32'(b_i);
      return {1'b0, prod};
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issues one request and waits (bounded) for done; lat counts edges after the accept edge.
  task automatic applyStimulus(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                               output int lat);
    @(negedge clk);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runCheck(input string name, input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                          input logic [15:0] exp_hi, input logic [15:0] exp_lo, input logic exp_dbz,
                          input int exp_lat);
    int lat;
    applyStimulus(op_i, a_i, b_i, lat);
    checkOutput({name, " done"}, 32'(done), 32'd1);
    checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, " result_hi"}, 32'(result_hi), 32'(exp_hi));
    checkOutput({name, " result_lo"}, 32'(result_lo), 32'(exp_lo));
    checkOutput({name, " dbz"}, 32'(dbz), 32'(exp_dbz));
    @(posedge clk);
    #1;
    checkOutput({name, " done width"}, 32'({done, busy}), 32'd0);
    checkOutput({name, " held"}, {result_hi, result_lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic [32:0] exp;
    logic        r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    int          idx;
    bit          saw_done;

    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;

    vecs[0] = '{"mul 1234x5678", 1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 16};
    vecs[1] = '{"mul FFFFxFFFF", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 16};
    vecs[2] = '{"mul 8000x2",    1'b0, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 1'b0, 16};
    vecs[3] = '{"mul 0xABCD",    1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 16};
    vecs[4] = '{"div 1000/7",    1'b1, 16'd1000, 16'd7,    16'h0006, 16'h008E, 1'b0, 16};
    vecs[5] = '{"div FFFF/8001", 1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 16};
    vecs[6] = '{"div FFFF/1",    1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 16};
    vecs[7] = '{"div 1234/0",    1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 0};
    vecs[8] = '{"div 5/10",      1'b1, 16'd5,    16'd10,   16'h0005, 16'h0000, 1'b0, 16};

    #1;
    checkOutput("reset outputs", {15'd0, busy, done, dbz, result_hi[13:0]}, 32'd0);
    checkOutput("reset results", {result_hi, result_lo}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      runCheck(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      r_op = 1'($urandom_range(0, 1));
      r_a  = 16'($urandom);
      r_b  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      exp  = refModel(r_op, r_a, r_b);
      runCheck($sformatf("rand%0d op%0d %0h,%0h", i, r_op, r_a, r_b), r_op, r_a, r_b,
               exp[31:16], exp[15:0], exp[32], (r_op && r_b == 16'd0) ? 0 : 16);
    end

    // start held high with fresh operands every cycle: accepts land on edges 0, 18, 36.
    for (int k = 0; k < 54; k++) begin
      held_op[k] = 1'($urandom_range(0, 1));
      held_a[k]  = 16'($urandom);
      held_b[k]  = 16'($urandom_range(1, 65535));
    end
    @(negedge clk);
    start = 1'b1;
    op    = held_op[0];
    a     = held_a[0];
    b     = held_b[0];
    for (int k = 0; k < 54; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("held done k%0d", k), 32'(done), 32'((k % 18) == 16));
      checkOutput($sformatf("held busy k%0d", k), 32'(busy), 32'((k % 18) != 17));
      if ((k % 18) >= 16) begin
        idx = k - (k % 18);
        exp = refModel(held_op[idx], held_a[idx], held_b[idx]);
        checkOutput($sformatf("held result k%0d", k), {result_hi, result_lo}, exp[31:0]);
      end
      if (k < 53) begin
        op = held_op[k+1];
        a  = held_a[k+1];
        b  = held_b[k+1];
      end else begin
        start = 1'b0;
      end
    end

    // Reset at E8 of a multiply aborts it asynchronously.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 16'hBEEF;
    b     = 16'h1357;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset flags", {29'd0, busy, done, dbz}, 32'd0);
    checkOutput("async reset results", {result_hi, result_lo}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    checkOutput("no done after reset", 32'(saw_done), 32'd0);
    runCheck("div 100/9 after reset", 1'b1, 16'd100, 16'd9, 16'd1, 16'd11, 1'b0, 16);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
